// File: rtl/pong_pkg.sv
// Shared pong definitions: PS/2 scan codes, key_state bit positions and the
// scan-code decode FSM encoding.
package pong_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_W    = 8'h1D;
  localparam logic [7:0] SC_S    = 8'h1B;
  localparam logic [7:0] SC_UP   = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;

  localparam int KEY_LU = 3;
  localparam int KEY_LD = 2;
  localparam int KEY_RU = 1;
  localparam int KEY_RD = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key outputs; master is the decoder side,
// slave is the consumer (game top or bench) that drives the raw PS/2 lines.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_state;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key_state, scan_code, code_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key_state, scan_code, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 receiver: line synchronizers, clock glitch filter, 11-bit frame shift,
// start/stop/parity check and inter-edge timeout.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_d,    // byte being loaded this cycle
  output logic       valid_d,   // good frame completes this cycle
  output logic       err_d,     // frame or timeout error this cycle
  output logic [7:0] byte_q,
  output logic       valid_q,
  output logic       err_q
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]    clk_sync, data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic [10:0]   shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;

  logic          fall;
  logic          last_bit;
  logic          good;
  logic          timeout_hit;
  logic [10:0]   frame;

  always_comb begin
    fall        = filt_clk && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));
    frame       = {data_sync[1], shreg[10:1]};
    last_bit    = fall && (bit_cnt == 4'd10);
    // frame[0] start, frame[8:1] data LSB first, frame[9] odd parity, frame[10] stop
    good        = !frame[0] && frame[10] && (^frame[9:1]);
    timeout_hit = (bit_cnt != 4'd0) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    valid_d     = last_bit && good;
    err_d       = (last_bit && !good) || timeout_hit;
    byte_d      = frame[8:1];
  end

  // NOTE: every state register here uses non-blocking assignments so all flops
  // sample pre-edge values; blocking would turn the synchronizer into a wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};

      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end

      if (fall) begin
        shreg   <= frame;
        bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        tmo_cnt <= '0;
      end else if (timeout_hit) begin
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      valid_q <= valid_d;
      err_q   <= err_d;
      if (valid_d) byte_q <= byte_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for pong: decodes make/break/E0 sequences from the
// receiver into a held-state vector for the four paddle keys.
module ps2_key_decoder
  import pong_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_key_decoder_if.master     bus
);

  logic [7:0] rx_byte_d, rx_byte_q;
  logic       rx_valid_d, rx_valid_q, rx_err_d, rx_err_q;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .byte_d   (rx_byte_d),
    .valid_d  (rx_valid_d),
    .err_d    (rx_err_d),
    .byte_q   (rx_byte_q),
    .valid_q  (rx_valid_q),
    .err_q    (rx_err_q)
  );

  dec_state_t state, state_next;
  logic [3:0] keys, keys_next;
  logic       apply_en, is_brk, is_ext;

  // Decoding on the receiver's pre-register strobes lets key_state land in the
  // same cycle code_valid is visible.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_next = state;
    keys_next  = keys;
    apply_en   = 1'b0;
    is_brk     = 1'b0;
    is_ext     = 1'b0;

    if (rx_err_d) begin
      state_next = ST_IDLE;
    end else if (rx_valid_d) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_byte_d == SC_EXT)      state_next = ST_EXT;
          else if (rx_byte_d == SC_BRK) state_next = ST_BRK;
          else                          apply_en   = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte_d == SC_BRK)      state_next = ST_EXT_BRK;
          else if (rx_byte_d != SC_EXT) begin
            apply_en   = 1'b1;
            is_ext     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_byte_d == SC_EXT) state_next = ST_EXT_BRK;
          else begin
            apply_en   = 1'b1;
            is_brk     = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          apply_en   = 1'b1;
          is_brk     = 1'b1;
          is_ext     = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end

    if (apply_en) begin
      if (!is_ext && rx_byte_d == SC_W)   keys_next[KEY_LU] = !is_brk;
      if (!is_ext && rx_byte_d == SC_S)   keys_next[KEY_LD] = !is_brk;
      if ( is_ext && rx_byte_d == SC_UP)  keys_next[KEY_RU] = !is_brk;
      if ( is_ext && rx_byte_d == SC_DOWN) keys_next[KEY_RD] = !is_brk;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      keys  <= '0;
    end else begin
      state <= state_next;
      keys  <= keys_next;
    end
  end

  assign bus.key_state  = keys;
  assign bus.scan_code  = rx_byte_q;
  assign bus.code_valid = rx_valid_q;
  assign bus.frame_err  = rx_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of single frames with expected
// pulse/scan/key results, then timeout, glitch and mid-frame reset sequences.
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 20;   // PS/2 half bit period in clk cycles

  logic clk = 1'b0;
  logic reset;
  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Pulse monitor, sampled away from the active edge.
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  logic [3:0] keys_at_valid = '0;

  always @(negedge clk) begin
    if (bus.code_valid) begin
      valid_cnt++;
      keys_at_valid = bus.key_state;
    end
    if (bus.frame_err) err_cnt++;
    if (bus.code_valid && bus.frame_err) both_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input bit par_ok);
    logic par;
    par = par_ok ? ~(^code) : (^code);
    return {1'b1, par, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      bus.ps2_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk  = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit par_ok);
    send_bits(mk_frame(code, par_ok), 11);
    repeat (2 * HALF) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         par_ok;
    bit         exp_valid;
    logic [7:0] exp_scan;
    logic [3:0] exp_keys;
  } vec_t;

  vec_t vecs[20];
  int   v0, e0;

  initial begin
    vecs[0]  = '{8'h75, 1'b1, 1'b1, 8'h75, 4'b0000}; // non-ext 75 ignored
    vecs[1]  = '{8'h1D, 1'b1, 1'b1, 8'h1D, 4'b1000}; // W make
    vecs[2]  = '{8'h1D, 1'b1, 1'b1, 8'h1D, 4'b1000}; // typematic
    vecs[3]  = '{8'hF0, 1'b1, 1'b1, 8'hF0, 4'b1000};
    vecs[4]  = '{8'h1D, 1'b1, 1'b1, 8'h1D, 4'b0000}; // W break
    vecs[5]  = '{8'hE0, 1'b1, 1'b1, 8'hE0, 4'b0000};
    vecs[6]  = '{8'h75, 1'b1, 1'b1, 8'h75, 4'b0010}; // Up make
    vecs[7]  = '{8'hE0, 1'b1, 1'b1, 8'hE0, 4'b0010};
    vecs[8]  = '{8'h72, 1'b1, 1'b1, 8'h72, 4'b0011}; // Down make
    vecs[9]  = '{8'hE0, 1'b1, 1'b1, 8'hE0, 4'b0011};
    vecs[10] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 4'b0011};
    vecs[11] = '{8'h75, 1'b1, 1'b1, 8'h75, 4'b0001}; // Up break
    vecs[12] = '{8'hF0, 1'b0, 1'b0, 8'h75, 4'b0001}; // bad parity
    vecs[13] = '{8'h1B, 1'b1, 1'b1, 8'h1B, 4'b0101}; // S make, prefix gone
    vecs[14] = '{8'hE0, 1'b1, 1'b1, 8'hE0, 4'b0101};
    vecs[15] = '{8'hE0, 1'b1, 1'b1, 8'hE0, 4'b0101}; // E0 E0 stays in EXT
    vecs[16] = '{8'h75, 1'b1, 1'b1, 8'h75, 4'b0111};
    vecs[17] = '{8'h72, 1'b1, 1'b1, 8'h72, 4'b0111}; // Down without E0
    vecs[18] = '{8'hE0, 1'b1, 1'b1, 8'hE0, 4'b0111};
    vecs[19] = '{8'h1D, 1'b1, 1'b1, 8'h1D, 4'b0111}; // W with E0

    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_key_state",  32'(bus.key_state),  32'h0);
    check("reset_scan_code",  32'(bus.scan_code),  32'h0);
    check("reset_code_valid", 32'(bus.code_valid), 32'h0);
    check("reset_frame_err",  32'(bus.frame_err),  32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].code, vecs[i].par_ok);
      check($sformatf("vec%0d_valid_pulses", i), 32'(valid_cnt - v0), vecs[i].exp_valid ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_err_pulses", i),   32'(err_cnt - e0),   vecs[i].exp_valid ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_scan_code", i),    32'(bus.scan_code),  32'(vecs[i].exp_scan));
      check($sformatf("vec%0d_key_state", i),    32'(bus.key_state),  32'(vecs[i].exp_keys));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_keys_with_valid", i), 32'(keys_at_valid), 32'(vecs[i].exp_keys));
    end

    // Stall after 5 bits, longer than the timeout.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(mk_frame(8'h1B, 1'b1), 5);
    repeat (TIMEOUT + 1000) @(negedge clk);
    check("timeout_err_pulses",   32'(err_cnt - e0),   32'd1);
    check("timeout_valid_pulses", 32'(valid_cnt - v0), 32'd0);
    check("timeout_scan_kept",    32'(bus.scan_code),  32'h1D);
    check("timeout_keys_kept",    32'(bus.key_state),  32'b0111);
    send_frame(8'h1D, 1'b1);
    check("after_timeout_scan", 32'(bus.scan_code),  32'h1D);
    check("after_timeout_keys", 32'(bus.key_state),  32'b1111);

    // Short clock glitches must not register as bits.
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int g = 0; g < 4; g++) begin
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (20) @(negedge clk);
    end
    repeat (TIMEOUT + 500) @(negedge clk);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_err",   32'(err_cnt - e0),   32'd0);
    send_frame(8'h72, 1'b1);
    check("post_glitch_scan",  32'(bus.scan_code),  32'h72);
    check("post_glitch_valid", 32'(valid_cnt - v0), 32'd1);
    check("post_glitch_keys",  32'(bus.key_state),  32'b1111);

    // Reset in the middle of a frame drops it silently.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(mk_frame(8'h1B, 1'b1), 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (TIMEOUT + 1000) @(negedge clk);
    check("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("midreset_no_err",   32'(err_cnt - e0),   32'd0);
    check("midreset_keys",     32'(bus.key_state),  32'h0);
    check("midreset_scan",     32'(bus.scan_code),  32'h0);
    send_frame(8'h1D, 1'b1);
    check("post_reset_scan", 32'(bus.scan_code), 32'h1D);
    check("post_reset_keys", 32'(bus.key_state), 32'b1000);

    check("valid_err_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
